// File: rtl/oam_dma.sv
// Sprite DMA: stalls the CPU after a trigger write and copies one source page
// into the OAM data port as read/write pairs, aligned to even bus cycles.
module oam_dma #(
  parameter logic [15:0] TRIGGER_ADDR = 16'h4014,
  parameter logic [15:0] DEST_ADDR    = 16'h2004,
  parameter int          LENGTH       = 256
) (
  input  logic        clk4,
  input  logic        n_reset,
  input  logic        cpu_ce,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rw,
  input  logic [7:0]  cpu_wdata,
  input  logic [7:0]  rdata,
  output logic        rdy,
  output logic        dma_grant,
  output logic [15:0] dma_addr,
  output logic        dma_rw,
  output logic [7:0]  dma_wdata
);

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE
  } state_t;

  localparam logic [8:0] LAST = 9'(LENGTH - 1);

  state_t     state;
  logic [8:0] idx;
  logic [7:0] page;
  logic       cyc_odd;

  always_ff @(posedge clk4 or negedge n_reset) begin
    if (!n_reset) begin
      state     <= IDLE;
      idx       <= '0;
      page      <= '0;
      cyc_odd   <= 1'b0;
      rdy       <= 1'b1;
      dma_grant <= 1'b0;
      dma_addr  <= '0;
      dma_rw    <= 1'b1;
      dma_wdata <= '0;
    end else if (cpu_ce) begin
      cyc_odd <= ~cyc_odd;
      unique case (state)
        IDLE: begin
          if (!cpu_rw && cpu_addr == TRIGGER_ADDR) begin
            page  <= cpu_wdata;
            rdy   <= 1'b0;
            state <= HALT;
          end
        end
        HALT: begin
          // the CPU only honours RDY on reads
          if (cpu_rw) begin
            dma_grant <= 1'b1;
            dma_rw    <= 1'b1;
            dma_addr  <= {page, 8'h00};
            state     <= cyc_odd ? READ : ALIGN;
          end
        end
        ALIGN: begin
          dma_addr <= {page, idx[7:0]};
          state    <= READ;
        end
        READ: begin
          dma_wdata <= rdata;
          dma_addr  <= DEST_ADDR;
          dma_rw    <= 1'b0;
          state     <= WRITE;
        end
        WRITE: begin
          if (idx == LAST) begin
            idx       <= '0;
            dma_grant <= 1'b0;
            rdy       <= 1'b1;
            dma_rw    <= 1'b1;
            state     <= IDLE;
          end else begin
            // low byte wraps inside the page, never carries
            idx      <= idx + 9'd1;
            dma_addr <= {page, idx[7:0] + 8'd1};
            dma_rw   <= 1'b1;
            state    <= READ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
